i2s_tx_stage: RTL and testbench
===============================

# i2s_tx_stage

Downstream output stage for the audio effects chain. It consumes the 16-bit AXI-Stream samples produced by the echo stage and serialises each sample as a standard I2S frame, sending the same mono sample on both channels. It has a one-entry holding buffer for backpressure and generates BCLK and LRCLK internally from pi_clk using clock enables. If no sample is available at a frame boundary, it sends a silent frame and flags an underrun.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width in bits (signed two's complement).
- SLOT_BITS, 16, BCLK periods per channel slot; must be ≥ DATA_WIDTH.
- CLK_DIV, 2, pi_clk cycles per BCLK half-period; must be ≥ 1.

Ports:
- pi_clk  in  1  single system clock; all logic runs on its rising edge.
- pi_sreset  in  1  reset, asynchronous and active-high (one clock; reset is asynchronous and active-high).
- pi_data  AXIS.slave  DATA_WIDTH  sample input: tdata, tvalid, tready, tlast.
- pi_enable  in  1  enables transmission; sampled only at frame boundaries.
- po_bclk  out  1  I2S bit clock, registered.
- po_lrclk  out  1  I2S word select: 0 = left, 1 = right; registered.
- po_sdata  out  1  I2S serial data, MSB first; registered.
- po_underrun  out  1  one-cycle pulse when a frame starts with no buffered sample.
- po_last_sent  out  1  one-cycle pulse when a frame built from a tlast sample starts.

## Operation
- Reset: every output is 0, pi_data.tready is 0, the holding buffer is empty, state is IDLE, and the divider and bit counter are 0. On deassertion, pi_data.tready rises on the first clock edge.
- Holding buffer: one {tdata, tlast} entry.
  - pi_data.tready = !hold_valid (registered).
  - A transfer happens when tvalid && tready; the entry is captured and hold_valid is set.
- Frame loading: at each frame start the entry moves into a 2*SLOT_BITS shift register, laid out as {sample, zero pad, sample, zero pad}, and hold_valid clears. The shift register drives po_sdata.
- State machine:
  - IDLE: bclk, lrclk and sdata are held at 0 and the divider is stopped. The buffer still accepts one sample. IDLE moves to RUN when pi_enable = 1.
  - RUN: the BCLK divider runs and a bit position counter pos counts 0..2*SLOT_BITS−1 and wraps. pos advances on each BCLK falling edge.
  - At each pos wrap to 0 (frame boundary), if pi_enable = 0 the block returns to IDLE. This also applies mid-stream, so an in-flight frame always completes.
- Bit timing: the new data bit for position pos and the new lrclk value are updated at the BCLK falling edge.
- Slot layout: sdata carries bit (DATA_WIDTH−1−(pos mod SLOT_BITS)) of the sample; positions beyond DATA_WIDTH in the slot carry 0.
- I2S one-bit delay: lrclk = ((pos+1) mod 2*SLOT_BITS) ≥ SLOT_BITS, so LRCLK changes one BCLK before each slot's MSB.
- Underrun: if hold_valid = 0 at a frame boundary in RUN, the frame is all zeros and po_underrun pulses once.
- Simultaneous events: if a frame-boundary load and a new AXIS transfer occur in the same cycle, no transfer can happen, because tready was 0 (buffer full). The new sample is accepted on the following cycle.
- po_last_sent pulses in the same cycle as the load of a tlast entry.
- Reset mid-frame: everything aborts immediately (asynchronous) and the buffered sample is discarded.

## Timing
- BCLK period: 2*CLK_DIV pi_clk cycles. Frame period: 4*CLK_DIV*SLOT_BITS pi_clk cycles (128 at default parameters).
- po_sdata and po_lrclk change in the pi_clk cycle where po_bclk goes 1→0, and are stable across the BCLK rising edge.
- Leaving IDLE: the first BCLK falling edge (pos = 0, frame load) occurs 2*CLK_DIV cycles after pi_enable is sampled high.
- Throughput: one sample accepted per frame. tready rises one cycle after the load.

## Structure
- Shared package audio_pkg: the I2S-related constants (default SLOT_BITS and CLK_DIV) and the typedef enum {IDLE, RUN} for this block's state.
- One natural sub-module, bclk_gen: a counter-based divider.
  - Inputs: run.
  - Outputs: the registered bclk, a fall_en pulse, and a rise_en pulse.
- The holding buffer, pos counter, shift register and FSM live in i2s_tx_stage.

## Test plan
All tests use the default parameters.
- Single sample 0x8001, then pi_enable = 1 → left slot sdata = 1,0×14,1 after the 1-BCLK delay, right slot identical. LRCLK low for 16 BCLKs then high, changing one BCLK before each MSB.
- pi_enable = 1 with no samples → all-zero frames, po_underrun pulses once per 128 cycles, tready stays 1.
- Back-to-back samples 0x1234, 0xABCD with tvalid held high → first accepted, then tready low until the frame load; frames carry 0x1234 then 0xABCD, with no underrun.
- Sample with tlast = 1 → po_last_sent pulses exactly once, in the cycle that sample's frame loads.
- pi_enable dropped at pos = 5 → frame completes all 32 positions, then bclk, lrclk and sdata go to 0 and stay there.
- pi_sreset asserted mid-frame → all outputs are 0 immediately (asynchronous). After release the buffer is empty and tready = 1 on the next edge.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the audio effects chain output side.
// Holds the default I2S framing constants and the state type used by
// the I2S transmit stage.
package audio_pkg;

  // Default BCLK periods per channel slot and pi_clk cycles per BCLK half-period.
  localparam int I2S_SLOT_BITS = 16;
  localparam int I2S_CLK_DIV   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

endpackage

// File: rtl/i2s_tx_stage_bclk_gen.sv
// bclk_gen
// Counter-based bit clock divider. While run is high, the registered bclk
// toggles every CLK_DIV clock cycles; while run is low, bclk and the divider
// are held at 0 so the first half-period after start is always a full one.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   run      in   divider enable
//   bclk     out  registered bit clock
//   fall_en  out  high in the cycle whose rising clk edge drives bclk 1->0
//   rise_en  out  high in the cycle whose rising clk edge drives bclk 0->1
module bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall_en,
  output logic rise_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tick;

  // tick marks the last cycle of a half-period; the edge after it toggles bclk.
  assign tick    = run && (div_q == DIV_W'(CLK_DIV - 1));
  assign fall_en = tick && bclk_q;
  assign rise_en = tick && !bclk_q;
  assign bclk    = bclk_q;

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!run) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (tick) begin
      div_d  = '0;
      bclk_d = !bclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx_stage.sv
// i2s_tx_stage
// Serialises 16-bit mono AXI-Stream samples into standard I2S frames, sending
// the same sample in the left and right slots. A one-entry holding buffer
// absorbs backpressure; a missing sample at a frame boundary produces a silent
// frame and an underrun pulse.
// Ports:
//   pi_clk          in   system clock
//   pi_sreset       in   asynchronous active-high reset
//   pi_data_tdata   in   sample (signed two's complement)
//   pi_data_tvalid  in   sample valid
//   pi_data_tready  out  buffer empty, registered
//   pi_data_tlast   in   marks the last sample of a stream
//   pi_enable       in   transmit enable, sampled at frame boundaries
//   po_bclk         out  I2S bit clock
//   po_lrclk        out  I2S word select (0 left, 1 right)
//   po_sdata        out  I2S serial data, MSB first
//   po_underrun     out  pulse when a frame starts with no buffered sample
//   po_last_sent    out  pulse when a frame built from a tlast sample starts
module i2s_tx_stage
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = I2S_SLOT_BITS,
  parameter int CLK_DIV    = I2S_CLK_DIV
) (
  input  logic                  pi_clk,
  input  logic                  pi_sreset,
  input  logic [DATA_WIDTH-1:0] pi_data_tdata,
  input  logic                  pi_data_tvalid,
  output logic                  pi_data_tready,
  input  logic                  pi_data_tlast,
  input  logic                  pi_enable,
  output logic                  po_bclk,
  output logic                  po_lrclk,
  output logic                  po_sdata,
  output logic                  po_underrun,
  output logic                  po_last_sent
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int POS_W      = $clog2(FRAME_BITS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);

  i2s_state_e                state_q, state_d;
  logic [POS_W-1:0]          pos_q, pos_d;
  logic [FRAME_BITS-1:0]     shift_q, shift_d;
  logic                      sdata_q, sdata_d;
  logic                      lrclk_q, lrclk_d;
  logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
  logic                      hold_last_q, hold_last_d;
  logic                      hold_valid_q, hold_valid_d;
  logic                      tready_q, tready_d;
  logic                      underrun_q, underrun_d;
  logic                      last_sent_q, last_sent_d;

  logic                      bclk_fall;
  logic                      bclk_rise;
  logic [SLOT_BITS-1:0]      slot_word;

  bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk     (pi_clk),
    .rst     (pi_sreset),
    .run     (state_q == RUN),
    .bclk    (po_bclk),
    .fall_en (bclk_fall),
    .rise_en (bclk_rise)
  );

  // Word select runs one bit ahead of the data so it changes before each MSB.
  function automatic logic lr_at(input logic [POS_W-1:0] p);
    return ((int'(p) + 1) % FRAME_BITS) >= SLOT_BITS;
  endfunction

  // Sample left-aligned in its slot, zero padded below the LSB.
  assign slot_word = SLOT_BITS'(hold_data_q) << (SLOT_BITS - DATA_WIDTH);

  // Next-state logic: frame sequencing on BCLK falling edges, plus the holding
  // buffer. A boundary load clears the buffer before the transfer check, but a
  // full buffer already has tready low, so both never land in one cycle.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    shift_d      = shift_q;
    sdata_d      = sdata_q;
    lrclk_d      = lrclk_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    underrun_d   = 1'b0;
    last_sent_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sdata_d = 1'b0;
        lrclk_d = 1'b0;
        pos_d   = '0;
        // Park pos on the last position so the first falling edge is a boundary.
        if (pi_enable) begin
          state_d = RUN;
          pos_d   = POS_LAST;
        end
      end
      RUN: begin
        if (bclk_fall) begin
          if (pos_q == POS_LAST) begin
            pos_d = '0;
            if (!pi_enable) begin
              state_d = IDLE;
              shift_d = '0;
              sdata_d = 1'b0;
              lrclk_d = 1'b0;
            end else begin
              if (hold_valid_q) begin
                shift_d      = {slot_word, slot_word};
                hold_valid_d = 1'b0;
                last_sent_d  = hold_last_q;
              end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
              end
              sdata_d = shift_d[FRAME_BITS-1];
              lrclk_d = lr_at('0);
            end
          end else begin
            pos_d   = pos_q + POS_W'(1);
            shift_d = shift_q << 1;
            sdata_d = shift_q[FRAME_BITS-2];
            lrclk_d = lr_at(pos_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pi_data_tvalid && tready_q) begin
      hold_data_d  = pi_data_tdata;
      hold_last_d  = pi_data_tlast;
      hold_valid_d = 1'b1;
    end

    tready_d = !hold_valid_d;
  end

  // State and output registers; reset aborts any frame and drops the buffer.
  always_ff @(posedge pi_clk or posedge pi_sreset) begin
    if (pi_sreset) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      shift_q      <= '0;
      sdata_q      <= 1'b0;
      lrclk_q      <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      tready_q     <= 1'b0;
      underrun_q   <= 1'b0;
      last_sent_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      shift_q      <= shift_d;
      sdata_q      <= sdata_d;
      lrclk_q      <= lrclk_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      tready_q     <= tready_d;
      underrun_q   <= underrun_d;
      last_sent_q  <= last_sent_d;
    end
  end

  // A rising bit clock edge only ever happens while running.
  rise_only_in_run : assert property (@(posedge pi_clk) disable iff (pi_sreset)
    bclk_rise |-> (state_q == RUN));

  assign pi_data_tready = tready_q;
  assign po_lrclk       = lrclk_q;
  assign po_sdata       = sdata_q;
  assign po_underrun    = underrun_q;
  assign po_last_sent   = last_sent_q;

endmodule

// File: tb/tb_i2s_tx_stage.sv
// tb_i2s_tx_stage
// Self-checking bench for i2s_tx_stage at default parameters. A driver pushes
// every accepted sample into a scoreboard queue; a monitor decodes the I2S
// output bit by bit and compares it with the frame expected from that queue.
module tb_i2s_tx_stage;

  localparam int DW       = 16;
  localparam int SLOT     = 16;
  localparam int CDIV     = 2;
  localparam int FRAME    = 2 * SLOT;
  localparam int BCLK_CYC = 2 * CDIV;

  logic          pi_clk = 1'b0;
  logic          pi_sreset = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          pi_enable = 1'b0;
  logic          pi_data_tready;
  logic          po_bclk, po_lrclk, po_sdata, po_underrun, po_last_sent;

  i2s_tx_stage dut (
    .pi_clk         (pi_clk),
    .pi_sreset      (pi_sreset),
    .pi_data_tdata  (tdata),
    .pi_data_tvalid (tvalid),
    .pi_data_tready (pi_data_tready),
    .pi_data_tlast  (tlast),
    .pi_enable      (pi_enable),
    .po_bclk        (po_bclk),
    .po_lrclk       (po_lrclk),
    .po_sdata       (po_sdata),
    .po_underrun    (po_underrun),
    .po_last_sent   (po_last_sent)
  );

  always #5 pi_clk = ~pi_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    since_reset = 0;
  logic  en_at_edge = 1'b0;
  int    mon_pos = -1;
  bit    mon_fall = 0;
  bit    mon_idle = 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // Reference: slot bit (pos mod SLOT) carries sample bit DW-1-that, zero beyond DW.
  function automatic logic model_bit(input logic [DW-1:0] s, input int p);
    int sp;
    sp = p % SLOT;
    return (sp < DW) ? s[DW-1-sp] : 1'b0;
  endfunction

  // Scoreboard producer: every handshake queues the sample with its edge number.
  always @(posedge pi_clk) begin
    item_t it;
    cyc++;
    en_at_edge = pi_enable;
    if (pi_sreset) begin
      sb_q.delete();
      since_reset = 0;
    end else begin
      since_reset++;
      if (tvalid && pi_data_tready) begin
        it.data = tdata;
        it.last = tlast;
        it.cyc  = cyc;
        sb_q.push_back(it);
      end
    end
  end

  // Monitor: decode falling BCLK edges into frame positions and compare.
  logic          bclk_prev = 1'b0;
  int            k = 0;
  int            last_fall = 0;
  logic [DW-1:0] cur = '0;

  always @(negedge pi_clk) begin
    bit start, exp_ur, exp_last, fell;
    start = 0; exp_ur = 0; exp_last = 0;
    mon_fall = 0;
    if (pi_sreset) begin
      mon_idle  = 1;
      k         = 0;
      bclk_prev = 1'b0;
      mon_pos   = -1;
    end else begin
      fell = bclk_prev && !po_bclk;
      if (mon_idle && po_bclk) begin
        mon_idle = 0;
        k        = 0;
      end
      if (fell) begin
        if (k > 0) check_output("bclk_period", cyc - last_fall, BCLK_CYC);
        last_fall = cyc;
        if ((k % FRAME == 0) && (k != 0) && !en_at_edge) begin
          mon_idle = 1;
          k        = 0;
          mon_pos  = -1;
        end else begin
          mon_pos  = k % FRAME;
          mon_fall = 1;
          if (mon_pos == 0) begin
            start = 1;
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
              cur      = sb_q[0].data;
              exp_last = sb_q[0].last;
              void'(sb_q.pop_front());
            end else begin
              cur    = '0;
              exp_ur = 1;
            end
          end
          check_output("sdata", po_sdata, model_bit(cur, mon_pos));
          check_output("lrclk", po_lrclk, (((mon_pos + 1) % FRAME) >= SLOT) ? 1 : 0);
          k++;
        end
      end
      if (mon_idle) begin
        check_output("idle_lrclk", po_lrclk, 0);
        check_output("idle_sdata", po_sdata, 0);
      end
      check_output("underrun", po_underrun, (start && exp_ur) ? 1 : 0);
      check_output("last_sent", po_last_sent, (start && exp_last) ? 1 : 0);
      if (since_reset >= 1) check_output("tready", pi_data_tready, (sb_q.size() == 0) ? 1 : 0);
      bclk_prev = po_bclk;
    end
  end

  task automatic apply_stimulus(input logic [DW-1:0] d, input logic l);
    @(negedge pi_clk);
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (pi_data_tready) begin
        @(posedge pi_clk);
        #1;
        return;
      end
      @(negedge pi_clk);
    end
    timeout_fail("handshake");
    tvalid = 1'b0;
  endtask

  task automatic release_bus();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 400; i++) begin
      @(negedge pi_clk);
      #1;
      if (mon_fall && mon_pos == p) return;
    end
    timeout_fail("wait_pos");
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_bclk"}, po_bclk, 0);
    check_output({tag, "_lrclk"}, po_lrclk, 0);
    check_output({tag, "_sdata"}, po_sdata, 0);
    check_output({tag, "_underrun"}, po_underrun, 0);
    check_output({tag, "_last_sent"}, po_last_sent, 0);
    check_output({tag, "_tready"}, pi_data_tready, 0);
  endtask

  initial begin
    int highs;
    $display("[TB] start");
    repeat (3) @(negedge pi_clk);
    check_all_zero("reset");
    pi_sreset = 1'b0;
    @(posedge pi_clk);
    #1;
    check_output("tready_after_reset", pi_data_tready, 1);

    // Single sample 0x8001, then underrun frames.
    apply_stimulus(16'h8001, 1'b0);
    release_bus();
    repeat (5) @(negedge pi_clk);
    pi_enable = 1'b1;
    repeat (3 * FRAME * BCLK_CYC) @(negedge pi_clk);

    // Back-to-back samples with tvalid held high.
    apply_stimulus(16'h1234, 1'b0);
    apply_stimulus(16'hABCD, 1'b1);
    release_bus();
    repeat (3 * FRAME * BCLK_CYC) @(negedge pi_clk);

    // Random samples with random gaps.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 150)) @(negedge pi_clk);
      apply_stimulus(16'($urandom), 1'($urandom_range(0, 1)));
      release_bus();
    end
    repeat (2 * FRAME * BCLK_CYC) @(negedge pi_clk);

    // Drop enable mid-frame; the frame completes, then the link goes quiet.
    wait_pos(5);
    pi_enable = 1'b0;
    repeat (120) @(negedge pi_clk);
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pi_clk);
      if (po_bclk) highs++;
    end
    check_output("idle_bclk_highs", highs, 0);

    // Sample accepted while idle, then restart.
    apply_stimulus(16'($urandom), 1'b1);
    release_bus();
    repeat (3) @(negedge pi_clk);
    pi_enable = 1'b1;
    repeat (2 * FRAME * BCLK_CYC) @(negedge pi_clk);

    // Asynchronous reset mid-frame with a sample in the buffer.
    wait_pos(2);
    apply_stimulus(16'h5A5A, 1'b0);
    release_bus();
    wait_pos(10);
    #3;
    pi_sreset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge pi_clk);
    pi_sreset = 1'b0;
    @(posedge pi_clk);
    #1;
    check_output("tready_after_midreset", pi_data_tready, 1);
    repeat (2 * FRAME * BCLK_CYC) @(negedge pi_clk);

    wait_pos(3);
    pi_enable = 1'b0;
    repeat (200) @(negedge pi_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
